// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit common-anode 7-segment scan driver with per-frame input capture.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zero digits (ones digit always shown).
module seg7_scan_driver #(
   parameter int unsigned SCAN_DIV = 1,
   parameter int unsigned DEAD_CYC = 0,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] val1,
   input  logic [3:0] val2,
   input  logic [3:0] val3,
   input  logic [3:0] val4,
   input  logic       blank,
   output logic [6:0] led_seg,
   output logic       a1,
   output logic       a2,
   output logic       a3,
   output logic       a4
);

   localparam int unsigned DIG_W = 4;
   localparam int unsigned SEG_W = 7;
   localparam int unsigned NDIG  = 4;
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [SEG_W-1:0] SEG_OFF   = 7'h7F;

   typedef enum logic [1:0] {
      DIG1 = 2'd0,
      DIG2 = 2'd1,
      DIG3 = 2'd2,
      DIG4 = 2'd3
   } state_e;

   state_e                      state_q, state_d;
   logic [CNT_W-1:0]            slot_cnt_q, slot_cnt_d;
   logic [NDIG-1:0][DIG_W-1:0]  shadow_q, shadow_d;   // [0] = thousands .. [3] = ones
   logic                        sh_blank_q, sh_blank_d;
   logic [SEG_W-1:0]            seg_q, seg_d;
   logic [NDIG-1:0]             an_q, an_d;            // [0] = a1

   logic [1:0]                  dig_idx;
   logic                        dead_c;
   logic [NDIG-1:0]             lz_c;

   assign dig_idx = state_q;

   // Anti-ghosting window at the start of each slot.
   if (DEAD_CYC == 0) begin : g_no_dead
      assign dead_c = 1'b0;
   end else begin : g_dead
      assign dead_c = (slot_cnt_q < CNT_W'(DEAD_CYC));
   end

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is suppressed when it and every more significant captured digit is zero.
   always_comb begin
      lz_c    = '0;
      lz_c[0] = (shadow_q[0] == 4'd0);
      lz_c[1] = lz_c[0] && (shadow_q[1] == 4'd0);
      lz_c[2] = lz_c[1] && (shadow_q[2] == 4'd0);
   end
`else
   assign lz_c = '0;
`endif

   function automatic logic [SEG_W-1:0] seg_decode(input logic [DIG_W-1:0] d);
      logic [SEG_W-1:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_OFF;
      endcase
      return s;
   endfunction

   // Scan sequencing, frame capture and next output values.
   always_comb begin
      state_d    = state_q;
      slot_cnt_d = slot_cnt_q + CNT_W'(1);
      shadow_d   = shadow_q;
      sh_blank_d = sh_blank_q;
      seg_d      = SEG_OFF;
      an_d       = '1;

      if (slot_cnt_q == SLOT_LAST) begin
         slot_cnt_d = '0;
         case (state_q)
            DIG1: state_d = DIG2;
            DIG2: state_d = DIG3;
            DIG3: state_d = DIG4;
            DIG4: state_d = DIG1;
         endcase
         if (state_q == DIG4) begin
            shadow_d[0] = val1;
            shadow_d[1] = val2;
            shadow_d[2] = val3;
            shadow_d[3] = val4;
            sh_blank_d  = blank;
         end
      end

      if (!sh_blank_q && !dead_c && !lz_c[dig_idx]) begin
         an_d[dig_idx] = 1'b0;
         seg_d         = seg_decode(shadow_q[dig_idx]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= DIG4;
         slot_cnt_q <= SLOT_LAST;
         shadow_q   <= '0;
         sh_blank_q <= 1'b1;
         seg_q      <= SEG_OFF;
         an_q       <= '1;
      end else begin
         state_q    <= state_d;
         slot_cnt_q <= slot_cnt_d;
         shadow_q   <= shadow_d;
         sh_blank_q <= sh_blank_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
      end
   end

   assign led_seg = seg_q;
   assign a1      = an_q[0];
   assign a2      = an_q[1];
   assign a3      = an_q[2];
   assign a4      = an_q[3];

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a fast-scan instance (SCAN_DIV=1) and a slow one with a dead cycle
// (SCAN_DIV=4, DEAD_CYC=1), checked against explicit patterns and a frame-arithmetic reference model.
module tb_seg7_scan_driver;

`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZ_EN = 1'b1;
`else
   localparam bit LZ_EN = 1'b0;
`endif

   localparam int SD_A   = 1;
   localparam int DEAD_A = 0;
   localparam int SD_B   = 4;
   localparam int DEAD_B = 1;
   localparam logic [10:0] DARK = 11'h7FF;

   logic       clk;
   logic       rst;
   logic [3:0] v1, v2, v3, v4;
   logic       blank;
   logic [6:0] seg_a, seg_b;
   logic       a1_a, a2_a, a3_a, a4_a;
   logic       a1_b, a2_b, a3_b, a4_b;

   int pass_cnt  = 0;
   int total_cnt = 0;

   seg7_scan_driver #(.SCAN_DIV(SD_A), .DEAD_CYC(DEAD_A), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .val1(v1), .val2(v2), .val3(v3), .val4(v4), .blank(blank),
      .led_seg(seg_a), .a1(a1_a), .a2(a2_a), .a3(a3_a), .a4(a4_a));

   seg7_scan_driver #(.SCAN_DIV(SD_B), .DEAD_CYC(DEAD_B), .CNT_W(8)) dut_b (
      .clk(clk), .rst(rst), .val1(v1), .val2(v2), .val3(v3), .val4(v4), .blank(blank),
      .led_seg(seg_b), .a1(a1_b), .a2(a2_b), .a3(a3_b), .a4(a4_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: n counts clock edges since reset release; each instance keeps the frame
   // snapshot taken at its frame start (every 4*SCAN_DIV edges) and the one visible one edge earlier.
   int          n;
   logic [16:0] sh_now_a, sh_prev_a, sh_now_b, sh_prev_b;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         n         <= 0;
         sh_now_a  <= 17'h00001;
         sh_prev_a <= 17'h00001;
         sh_now_b  <= 17'h00001;
         sh_prev_b <= 17'h00001;
      end else begin
         n         <= n + 1;
         sh_prev_a <= sh_now_a;
         sh_prev_b <= sh_now_b;
         if (n % (4 * SD_A) == 0) sh_now_a <= {v1, v2, v3, v4, blank};
         if (n % (4 * SD_B) == 0) sh_now_b <= {v1, v2, v3, v4, blank};
      end
   end

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic lz_sup(input logic [15:0] dg, input int dig);
      logic z;
      z = LZ_EN && (dig < 3);
      for (int j = 0; j <= dig && j < 4; j++)
         if (dg[15-4*j -: 4] != 4'd0) z = 1'b0;
      return z;
   endfunction

   // Expected {a4,a3,a2,a1,led_seg} after edge nn: the slot shown is the one active after edge nn-1.
   function automatic logic [10:0] exp_out(input int sd, input int dead, input int nn,
                                           input logic [16:0] sh);
      int          cnt, dig;
      logic [3:0]  an;
      logic [3:0]  d;
      logic [10:0] r;
      r = DARK;
      if (nn >= 2) begin
         cnt = (nn - 2) % sd;
         dig = ((nn - 2) / sd) % 4;
         d   = sh[16-4*dig -: 4];
         an  = ~(4'b0001 << dig);
         if (!sh[0] && cnt >= dead && !lz_sup(sh[16:1], dig)) r = {an, seg_of(d)};
      end
      return r;
   endfunction

   function automatic logic [10:0] obs_a();
      return {a4_a, a3_a, a2_a, a1_a, seg_a};
   endfunction

   function automatic logic [10:0] obs_b();
      return {a4_b, a3_b, a2_b, a1_b, seg_b};
   endfunction

   task automatic apply_reset(input logic [3:0] x1, x2, x3, x4, input logic b);
      @(negedge clk);
      rst = 1'b0;
      v1 = x1; v2 = x2; v3 = x3; v4 = x4; blank = b;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total_cnt++;
      if (obs_a() !== DARK) $display("FAIL reset_a: got %h want %h", obs_a(), DARK);
      else pass_cnt++;
      total_cnt++;
      if (obs_b() !== DARK) $display("FAIL reset_b: got %h want %h", obs_b(), DARK);
      else pass_cnt++;
   endtask

   task automatic test_basic_scan();
      logic [10:0] exp_t[5];
      exp_t[0] = {4'b1110, 7'b1111001};
      exp_t[1] = {4'b1101, 7'b0100100};
      exp_t[2] = {4'b1011, 7'b0110000};
      exp_t[3] = {4'b0111, 7'b0011001};
      exp_t[4] = {4'b1110, 7'b1111001};
      apply_reset(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
      @(negedge clk);
      total_cnt++;
      if (obs_a() !== DARK) $display("FAIL first_edge_dark: got %h want %h", obs_a(), DARK);
      else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total_cnt++;
         if (obs_a() !== exp_t[i])
            $display("FAIL basic_scan cyc%0d: got %h want %h", i + 2, obs_a(), exp_t[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_dead_cycles();
      logic [10:0] e;
      apply_reset(4'd9, 4'd9, 4'd9, 4'd9, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         e = (i % 4 == 0) ? DARK : {~(4'b0001 << ((i / 4) % 4)), 7'b0010000};
         total_cnt++;
         if (obs_b() !== e) $display("FAIL dead_cycle i=%0d: got %h want %h", i, obs_b(), e);
         else pass_cnt++;
      end
   endtask

   task automatic test_midframe_change();
      logic [10:0] exp_t[5];
      logic [10:0] eb;
      exp_t[0] = {4'b1110, 7'b0010010};
      exp_t[1] = {4'b1101, 7'b1111001};
      exp_t[2] = {4'b1011, 7'b0100100};
      exp_t[3] = {4'b0111, 7'b0110000};
      exp_t[4] = {4'b1110, 7'b1111000};
      apply_reset(4'd5, 4'd1, 4'd2, 4'd3, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total_cnt++;
         if (obs_a() !== exp_t[i])
            $display("FAIL midframe cyc%0d: got %h want %h", i + 2, obs_a(), exp_t[i]);
         else pass_cnt++;
         eb = exp_out(SD_B, DEAD_B, n, sh_prev_b);
         total_cnt++;
         if (obs_b() !== eb) $display("FAIL midframe_b n=%0d: got %h want %h", n, obs_b(), eb);
         else pass_cnt++;
         if (i == 0) v1 = 4'd7;
      end
   endtask

   task automatic test_blank();
      logic [10:0] e;
      logic [6:0]  segs[4];
      segs[0] = 7'b0011001; segs[1] = 7'b0110000; segs[2] = 7'b0100100; segs[3] = 7'b1111001;
      apply_reset(4'd4, 4'd3, 4'd2, 4'd1, 1'b1);
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         e = (i < 4) ? DARK : {~(4'b0001 << (i % 4)), segs[i % 4]};
         total_cnt++;
         if (obs_a() !== e) $display("FAIL blank cyc%0d: got %h want %h", i + 2, obs_a(), e);
         else pass_cnt++;
         if (i == 2) blank = 1'b0;
         if (i == 4) blank = 1'b1;
         if (i == 6) blank = 1'b0;
      end
   endtask

   task automatic test_reset_midframe();
      logic [10:0] e;
      apply_reset(4'd8, 4'd6, 4'd4, 4'd2, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      total_cnt++;
      if (obs_a() !== DARK) $display("FAIL async_reset_a: got %h want %h", obs_a(), DARK);
      else pass_cnt++;
      total_cnt++;
      if (obs_b() !== DARK) $display("FAIL async_reset_b: got %h want %h", obs_b(), DARK);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (obs_a() !== DARK) $display("FAIL reset_held: got %h want %h", obs_a(), DARK);
      else pass_cnt++;
      rst = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (obs_a() !== DARK) $display("FAIL restart_first_edge: got %h want %h", obs_a(), DARK);
      else pass_cnt++;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         e = (i == 0) ? {4'b1110, 7'b0000000} : {4'b1101, 7'b0000010};
         total_cnt++;
         if (obs_a() !== e) $display("FAIL restart cyc%0d: got %h want %h", i + 2, obs_a(), e);
         else pass_cnt++;
      end
   endtask

   task automatic test_leading_zero();
      logic [10:0] exp_t[4];
      exp_t[0] = LZ_EN ? DARK : {4'b1110, 7'b1000000};
      exp_t[1] = LZ_EN ? DARK : {4'b1101, 7'b1000000};
      exp_t[2] = {4'b1011, 7'b0000010};
      exp_t[3] = {4'b0111, 7'b1000000};
      apply_reset(4'd0, 4'd0, 4'd6, 4'd0, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total_cnt++;
         if (obs_a() !== exp_t[i])
            $display("FAIL leading_zero slot%0d: got %h want %h", i + 1, obs_a(), exp_t[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      logic [10:0] ea, eb;
      apply_reset(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         ea = exp_out(SD_A, DEAD_A, n, sh_prev_a);
         eb = exp_out(SD_B, DEAD_B, n, sh_prev_b);
         total_cnt++;
         if (obs_a() !== ea) $display("FAIL random_a i=%0d: got %h want %h", i, obs_a(), ea);
         else pass_cnt++;
         total_cnt++;
         if (obs_b() !== eb) $display("FAIL random_b i=%0d: got %h want %h", i, obs_b(), eb);
         else pass_cnt++;
         // Mostly BCD with some invalid codes and many zeros to exercise leading-zero paths.
         case ($urandom_range(0, 3))
            0: v1 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            1: v2 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            2: v3 = 4'($urandom_range(0, 9));
            default: v4 = 4'($urandom_range(0, 15));
         endcase
         blank = ($urandom_range(0, 7) == 0);
         if (i == 150) rst = 1'b0;
         if (i == 152) rst = 1'b1;
      end
   endtask

   initial begin
      rst = 1'b0;
      v1 = 4'd0; v2 = 4'd0; v3 = 4'd0; v4 = 4'd0;
      blank = 1'b0;
      test_reset();
      test_basic_scan();
      test_dead_cycles();
      test_midframe_change();
      test_blank();
      test_reset_midframe();
      test_leading_zero();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
